pc_fetch_stage: RTL and testbench

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage.sv | 101 ++++++++++
 tb/tb_pc_fetch_stage.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: IF stage of a 5-stage pipeline. Holds the PC and the IF/ID
// register, applies load-use stalls and Jump/branch redirects from ID, and
// inserts a single-cycle bubble (SQUASH state) after each redirect.
// Optional macro PC_FETCH_PERF_CNT_EN adds redirect/stall performance counters.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        Jump,
    input  logic        PCSrc,
    input  logic [31:0] jump_addr,
    input  logic [31:0] b_tgt,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
`ifdef PC_FETCH_PERF_CNT_EN
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        squash
);

    typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    logic [31:0] pc_plus4;
    logic [31:0] redir_tgt;
    logic        redirect;

    // Next sequential PC and redirect target; Jump outranks the branch.
    // Targets are forced word aligned so the PC low bits stay zero.
    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        redir_tgt = Jump ? {jump_addr[31:2], 2'b00} : {b_tgt[31:2], 2'b00};
        // The instruction in ID is a bubble while squashing, so its redirect
        // lines cannot be trusted and are dropped.
        redirect  = !stall && (state_q == RUN) && (Jump || PCSrc);
    end

    // PC, IF/ID register and RUN/SQUASH control in one registered FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (stall) begin
            // Load-use stall: everything holds, redirects wait for ID to move.
            state_q <= state_q;
        end else if (redirect) begin
            state_q <= SQUASH;
            pc_q    <= redir_tgt;
            instr_q <= NOP_WORD;
            pc4_q   <= pc_plus4;
            valid_q <= 1'b0;
        end else begin
            state_q <= RUN;
            pc_q    <= pc_plus4;
            instr_q <= imem_rdata;
            pc4_q   <= pc_plus4;
            valid_q <= 1'b1;
        end
    end

`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;

    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= 32'd0;
            stall_cnt_q    <= 32'd0;
        end else begin
            if (redirect) redirect_cnt_q <= redirect_cnt_q + 32'd1;
            if (stall)    stall_cnt_q    <= stall_cnt_q + 32'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign squash      = (state_q == SQUASH);

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed + randomized scoreboard bench for pc_fetch_stage.
// A driver applies inputs on the falling edge and pushes the predicted
// post-edge state; a monitor pops and compares one cycle later.
module tb_pc_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, Jump, PCSrc;
    logic [31:0] jump_addr, b_tgt, imem_rdata;
    logic [31:0] imem_addr, if_id_instr, if_id_pc4;
    logic        if_id_valid, squash;
`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem(imem_addr);

    pc_fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .clk(clk), .rst(rst), .stall(stall), .Jump(Jump), .PCSrc(PCSrc),
        .jump_addr(jump_addr), .b_tgt(b_tgt), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid),
`ifdef PC_FETCH_PERF_CNT_EN
        .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt),
`endif
        .squash(squash)
    );

    typedef struct {
        logic [31:0] pc, instr, pc4;
        logic        valid, sq;
        logic [31:0] rcnt, scnt;
    } exp_t;

    exp_t q[$];
    exp_t m;          // reference model state
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the stage should hold after one clock edge.
    task automatic step(input logic r, input logic s, input logic j, input logic b,
                        input logic [31:0] ja, input logic [31:0] bt);
        @(negedge clk);
        rst = r; stall = s; Jump = j; PCSrc = b; jump_addr = ja; b_tgt = bt;
        if (r) begin
            m.pc = RESET_PC; m.instr = NOP_WORD; m.pc4 = 0; m.valid = 0; m.sq = 0;
            m.rcnt = 0; m.scnt = 0;
        end else if (s) begin
            m.scnt = m.scnt + 1;
        end else if (!m.sq && (j || b)) begin
            m.pc4   = m.pc + 4;
            m.instr = NOP_WORD;
            m.valid = 0;
            m.pc    = (j ? ja : bt) & 32'hFFFF_FFFC;
            m.sq    = 1;
            m.rcnt  = m.rcnt + 1;
        end else begin
            m.instr = mem(m.pc);
            m.pc4   = m.pc + 4;
            m.pc    = m.pc + 4;
            m.valid = 1;
            m.sq    = 0;
        end
        q.push_back(m);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    // Monitor: compare the DUT against the oldest prediction after each edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("imem_addr",   imem_addr,   e.pc);
            chk("if_id_instr", if_id_instr, e.instr);
            chk("if_id_pc4",   if_id_pc4,   e.pc4);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("squash",      {31'd0, squash},      {31'd0, e.sq});
`ifdef PC_FETCH_PERF_CNT_EN
            chk("redirect_cnt", redirect_cnt, e.rcnt);
            chk("stall_cnt",    stall_cnt,    e.scnt);
`endif
        end
    end

    initial begin
        rst = 1; stall = 0; Jump = 0; PCSrc = 0; jump_addr = 0; b_tgt = 0;
        m = '{default: '0};
        // Reset then straight-line fetch 0 -> 4 -> 8 -> C.
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 1, 1, 32'h500, 32'h600);   // reset beats redirect
        seq(4);                                // PC now 0x10
        // Jump from 0x10 to 0x400, one squash cycle, then 0x404.
        step(0, 0, 1, 0, 32'h400, 32'h0);
        step(0, 0, 1, 1, 32'h999, 32'h777);   // ignored while squashing
        seq(1);
        // Jump and branch together: jump wins.
        step(0, 0, 1, 1, 32'h200, 32'h80);
        seq(2);
        // Two-cycle stall with a pending branch, then the branch is taken.
        step(0, 1, 0, 1, 32'h0, 32'h3000);
        step(0, 1, 0, 1, 32'h0, 32'h3000);
        step(0, 0, 0, 1, 32'h0, 32'h3000);
        step(0, 1, 0, 0, 32'h0, 32'h0);       // stall holds SQUASH
        seq(2);
        // Wrap at the top of the address space, then unaligned jump target.
        step(0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0);
        seq(1);
        step(0, 0, 1, 0, 32'h103, 32'h0);
        seq(1);
        // Reset while in SQUASH.
        step(0, 0, 0, 1, 32'h0, 32'h44);
        step(1, 0, 1, 0, 32'h88, 32'h0);
        seq(2);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 $urandom, $urandom);
        end
        @(negedge clk);
        rst = 0; stall = 0; Jump = 0; PCSrc = 0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
